alu_operand_a_stage: RTL and testbench
======================================

# alu_operand_a_stage

Parametrised, registered successor to the ALU A-operand selector. Selects one of `NUM_SRC` operand sources (PC, temp reg A, MDR, …) or constant zero, and captures the result in a 2-entry skid buffer with valid/ready handshakes on both sides. It sits between the register-read stage and the ALU. Source order is preserved, and an out-of-range select yields a defined zero instead of X.

## Interface
- `WIDTH`, 32: data width of every source and of the output.
- `NUM_SRC`, 3: number of data sources; select value `NUM_SRC` means constant zero.
- `SEL_W`, `$clog2(NUM_SRC+1)`: select width; local, derived.

Ports:
- `clk`  in  1  clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-high; clears all state immediately.
- `src_data`  in  `NUM_SRC*WIDTH`  flattened sources; source i occupies `[i*WIDTH +: WIDTH]`.
- `sel`  in  `SEL_W`  source select, sampled only on an accepted transfer.
- `in_valid`  in  1  upstream presents `sel`/`src_data`.
- `in_ready`  out  1  stage can accept; equals NOT `skid_valid` (registered).
- `out_data`  out  `WIDTH`  selected operand toward the ALU.
- `out_valid`  out  1  `out_data` holds a valid operand.
- `out_ready`  in  1  ALU consumes `out_data`.
- `count`  out  2  entries held (0..2).
- `sel_err`  out  1  present only when `ALU_A_SEL_ERR_EN` is defined; see Configuration.

## Operation
- **Selected value** (combinational):
  - `sel < NUM_SRC` selects source `sel`.
  - `sel == NUM_SRC` selects zero.
  - `sel > NUM_SRC` selects zero.
- Accept: `in_valid && in_ready`. Drain: `out_valid && out_ready`.
- **State encoding:** `count`, with EMPTY=0, ONE=1, FULL=2.
- **Transitions:**
  - EMPTY + accept: load the output register. Go to ONE.
  - ONE + accept + drain: load the output register with the new value. Stay in ONE.
  - ONE + accept, no drain: load the skid register. Go to FULL.
  - ONE + drain, no accept: go to EMPTY. `out_data` keeps its last value.
  - FULL + drain: move the skid register to the output register. Go to ONE. No accept is possible, since `in_ready` = 0.
  - No other combination changes state.
- Ordering is strictly FIFO. No data is dropped or duplicated.
- **Bubble-free throughput:** 1 operand per cycle while `out_ready` = 1.
- **Reset values:**
  - `out_valid` = 0, `out_data` = 0, `count` = 0.
  - Skid register = 0, skid valid = 0, so `in_ready` = 1.
  - `sel_err` = 0.
- **Reset mid-operation:** all held operands are discarded with no drain. The first accept after reset deassertion behaves as from EMPTY.

## Timing
- **Latency:** an operand accepted at edge k appears on `out_data` with `out_valid` = 1 after edge k when the stage was EMPTY, or ONE with a drain in the same cycle. Otherwise it appears after the edge on which it reaches the head.
- `in_ready` is a register output. There is no combinational path from `out_ready` to `in_ready`.
- `out_data`/`out_valid` are register outputs. There is no combinational path from the inputs.
- `out_data` is stable while `out_valid` = 1 and `out_ready` = 0.
- `in_ready` falls on the edge that fills the skid register. It rises on the edge of the drain from FULL.

## Configuration
- Macro: `ALU_A_SEL_ERR_EN`.
- **Defined:**
  - Port `sel_err` exists.
  - It is a sticky flag, set on the edge after any accept with `sel > NUM_SRC`.
  - It is cleared only by `reset`.
  - The data path still delivers zero for that operand.
- **Undefined:** no `sel_err` port and no flag register. Out-of-range selects silently yield zero.

## Test plan
- **Reset:** assert `reset` mid-stream with `count` = 2. Required: immediately `out_valid` = 0, `count` = 0, `in_ready` = 1, `out_data` = 0.
- **Select decode:** WIDTH=32, NUM_SRC=3, sources 0x0000_0040 / 0xDEAD_BEEF / 0x1234_5678, `out_ready` = 1, `sel` = 0,1,2,3 on consecutive cycles. Required: 0x40, 0xDEADBEEF, 0x12345678, 0 on `out_data` on consecutive cycles, with no bubble.
- **Backpressure:** `out_ready` = 0, accept A then B. Required: `count` = 2, `in_ready` = 0, `out_data` = A held. Then `out_ready` = 1 for 2 cycles. Required: A then B delivered, `in_ready` back to 1 after the first drain.
- **Simultaneous:** in ONE with `out_ready` = 1 and `in_valid` = 1 every cycle for 8 cycles. Required: `count` stays 1 and 8 operands emerge in order.
- **Out-of-range:** `sel` = 3'b111 with NUM_SRC=3 (SEL_W=2 ⇒ use NUM_SRC=4, SEL_W=3, `sel` = 7). Required: `out_data` = 0. With `ALU_A_SEL_ERR_EN` defined, `sel_err` = 1 and stays 1 until reset.

Source files
------------

// File: rtl/alu_operand_a_stage_if.sv
// alu_operand_a_stage_if: handshake bundle between register-read, the A-operand stage and the ALU
// Signals:
//   src_data  flattened operand sources, source i at [i*WIDTH +: WIDTH]
//   sel       source select (NUM_SRC and above select zero)
//   in_valid  / in_ready   upstream handshake
//   out_data  / out_valid / out_ready  downstream handshake toward the ALU
//   count     entries held by the stage (0..2)
//   sel_err   sticky out-of-range select flag, only with ALU_A_SEL_ERR_EN
// Modports: master = upstream/ALU side driving the stage, slave = the stage itself.
interface alu_operand_a_stage_if #(
    parameter int WIDTH   = 32,
    parameter int NUM_SRC = 3
);
    localparam int SEL_W = $clog2(NUM_SRC + 1);
    logic [NUM_SRC*WIDTH-1:0] src_data;
    logic [SEL_W-1:0]         sel;
    logic                     in_valid;
    logic                     in_ready;
    logic [WIDTH-1:0]         out_data;
    logic                     out_valid;
    logic                     out_ready;
    logic [1:0]               count;
`ifdef ALU_A_SEL_ERR_EN
    logic                     sel_err;
    modport master (
        output src_data, sel, in_valid, out_ready,
        input  in_ready, out_data, out_valid, count, sel_err
    );
    modport slave (
        input  src_data, sel, in_valid, out_ready,
        output in_ready, out_data, out_valid, count, sel_err
    );
`else
    modport master (
        output src_data, sel, in_valid, out_ready,
        input  in_ready, out_data, out_valid, count
    );
    modport slave (
        input  src_data, sel, in_valid, out_ready,
        output in_ready, out_data, out_valid, count
    );
`endif
endinterface

// File: rtl/alu_operand_a_stage.sv
// alu_operand_a_stage: registered ALU A-operand selector with a 2-entry skid buffer
// Ports:
//   clk    rising-edge clock
//   reset  asynchronous active-high reset, discards all held operands
//   bus    alu_operand_a_stage_if.slave: source select, valid/ready on both sides, count
// Optional feature macro: ALU_A_SEL_ERR_EN adds a sticky sel_err flag raised by any
// accepted select above NUM_SRC; without it out-of-range selects silently yield zero.
module alu_operand_a_stage #(
    parameter int WIDTH   = 32,
    parameter int NUM_SRC = 3
) (
    input logic                  clk,
    input logic                  reset,
    alu_operand_a_stage_if.slave bus
);
    localparam int SEL_W = $clog2(NUM_SRC + 1);
    typedef enum logic [1:0] {EMPTY = 2'd0, ONE = 2'd1, FULL = 2'd2} state_e;
    state_e           state_q;
    logic [WIDTH-1:0] out_data_q;
    logic [WIDTH-1:0] skid_q;
    logic [WIDTH-1:0] sel_data;
    logic             out_valid_q;
    logic             skid_valid_q;
    logic             accept;
    logic             drain;
    // Any select with no matching source (== NUM_SRC or beyond) falls through to zero.
    always_comb begin
        sel_data = '0;
        for (int i = 0; i < NUM_SRC; i++)
            sel_data = (bus.sel == SEL_W'(i)) ? bus.src_data[i*WIDTH +: WIDTH] : sel_data;
    end
    // in_ready comes straight from the skid flag, so out_ready never reaches it combinationally.
    assign accept = bus.in_valid && !skid_valid_q;
    assign drain  = out_valid_q && bus.out_ready;
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= EMPTY;
            out_data_q   <= '0;
            skid_q       <= '0;
            out_valid_q  <= 1'b0;
            skid_valid_q <= 1'b0;
        end else begin
            case (state_q)
                EMPTY: if (accept) begin
                    out_data_q  <= sel_data;
                    out_valid_q <= 1'b1;
                    state_q     <= ONE;
                end
                ONE: if (accept && drain) begin
                    out_data_q <= sel_data;
                end else if (accept) begin
                    skid_q       <= sel_data;
                    skid_valid_q <= 1'b1;
                    state_q      <= FULL;
                end else if (drain) begin
                    // out_data keeps its last value while empty.
                    out_valid_q <= 1'b0;
                    state_q     <= EMPTY;
                end
                FULL: if (drain) begin
                    out_data_q   <= skid_q;
                    skid_valid_q <= 1'b0;
                    state_q      <= ONE;
                end
                default: begin
                    out_valid_q  <= 1'b0;
                    skid_valid_q <= 1'b0;
                    state_q      <= EMPTY;
                end
            endcase
        end
    end
    assign bus.in_ready  = !skid_valid_q;
    assign bus.out_data  = out_data_q;
    assign bus.out_valid = out_valid_q;
    assign bus.count     = 2'(state_q);
`ifdef ALU_A_SEL_ERR_EN
    logic sel_err_q;
    always_ff @(posedge clk or posedge reset) begin
        if (reset) sel_err_q <= 1'b0;
        else if (accept && bus.sel > SEL_W'(NUM_SRC)) sel_err_q <= 1'b1;
    end
    assign bus.sel_err = sel_err_q;
`endif
endmodule

// File: tb/tb_alu_operand_a_stage.sv
// tb_alu_operand_a_stage: directed self-checking bench for alu_operand_a_stage
module tb_alu_operand_a_stage;
    logic clk = 1'b0;
    logic reset = 1'b0;
    int   pass_cnt = 0;
    int   total_cnt = 0;
    alu_operand_a_stage_if #(.WIDTH(32), .NUM_SRC(3)) bus3 ();
    alu_operand_a_stage_if #(.WIDTH(32), .NUM_SRC(4)) bus4 ();
    alu_operand_a_stage #(.WIDTH(32), .NUM_SRC(3)) dut3 (.clk(clk), .reset(reset), .bus(bus3));
    alu_operand_a_stage #(.WIDTH(32), .NUM_SRC(4)) dut4 (.clk(clk), .reset(reset), .bus(bus4));
    always #5 clk = ~clk;

    task automatic test_reset;
        bus3.src_data = '0; bus3.sel = '0; bus3.in_valid = 1'b0; bus3.out_ready = 1'b0;
        bus4.src_data = '0; bus4.sel = '0; bus4.in_valid = 1'b0; bus4.out_ready = 1'b0;
        #2 reset = 1'b1;
        #1;
        total_cnt++; if (bus3.out_valid !== 1'b0) $display("FAIL reset out_valid: got %b want 0", bus3.out_valid); else pass_cnt++;
        total_cnt++; if (bus3.count !== 2'd0) $display("FAIL reset count: got %0d want 0", bus3.count); else pass_cnt++;
        total_cnt++; if (bus3.in_ready !== 1'b1) $display("FAIL reset in_ready: got %b want 1", bus3.in_ready); else pass_cnt++;
        total_cnt++; if (bus3.out_data !== 32'h0) $display("FAIL reset out_data: got %h want 0", bus3.out_data); else pass_cnt++;
`ifdef ALU_A_SEL_ERR_EN
        total_cnt++; if (bus4.sel_err !== 1'b0) $display("FAIL reset sel_err: got %b want 0", bus4.sel_err); else pass_cnt++;
`endif
        @(posedge clk); #1;
        reset = 1'b0;
    endtask

    task automatic test_select_decode;
        logic [31:0] exp_v [4];
        exp_v = '{32'h0000_0040, 32'hDEAD_BEEF, 32'h1234_5678, 32'h0};
        bus3.src_data = {32'h1234_5678, 32'hDEAD_BEEF, 32'h0000_0040};
        bus3.out_ready = 1'b1;
        bus3.in_valid = 1'b1;
        bus3.sel = 2'd0;
        for (int k = 0; k < 4; k++) begin
            @(posedge clk); #1;
            total_cnt++; if (bus3.out_valid !== 1'b1 || bus3.out_data !== exp_v[k])
                $display("FAIL decode sel=%0d: got valid=%b data=%h want valid=1 data=%h", k, bus3.out_valid, bus3.out_data, exp_v[k]);
            else pass_cnt++;
            if (k < 3) bus3.sel = 2'(k + 1);
            else bus3.in_valid = 1'b0;
        end
        @(posedge clk); #1;
        total_cnt++; if (bus3.out_valid !== 1'b0 || bus3.count !== 2'd0)
            $display("FAIL decode drain: got valid=%b count=%0d want valid=0 count=0", bus3.out_valid, bus3.count);
        else pass_cnt++;
    endtask

    task automatic test_backpressure;
        bus3.out_ready = 1'b0;
        bus3.in_valid = 1'b1;
        bus3.sel = 2'd0;
        bus3.src_data = {32'h0, 32'h0, 32'hAAAA_0001};
        @(posedge clk); #1;
        bus3.src_data = {32'h0, 32'h0, 32'hBBBB_0002};
        @(posedge clk); #1;
        bus3.in_valid = 1'b0;
        total_cnt++; if (bus3.count !== 2'd2) $display("FAIL bp full count: got %0d want 2", bus3.count); else pass_cnt++;
        total_cnt++; if (bus3.in_ready !== 1'b0) $display("FAIL bp full in_ready: got %b want 0", bus3.in_ready); else pass_cnt++;
        total_cnt++; if (bus3.out_data !== 32'hAAAA_0001) $display("FAIL bp head A: got %h want aaaa0001", bus3.out_data); else pass_cnt++;
        @(posedge clk); #1;
        total_cnt++; if (bus3.out_data !== 32'hAAAA_0001 || bus3.out_valid !== 1'b1)
            $display("FAIL bp hold: got valid=%b data=%h want valid=1 data=aaaa0001", bus3.out_valid, bus3.out_data);
        else pass_cnt++;
        bus3.out_ready = 1'b1;
        @(posedge clk); #1;
        total_cnt++; if (bus3.out_data !== 32'hBBBB_0002) $display("FAIL bp head B: got %h want bbbb0002", bus3.out_data); else pass_cnt++;
        total_cnt++; if (bus3.in_ready !== 1'b1 || bus3.count !== 2'd1)
            $display("FAIL bp after drain: got in_ready=%b count=%0d want in_ready=1 count=1", bus3.in_ready, bus3.count);
        else pass_cnt++;
        @(posedge clk); #1;
        total_cnt++; if (bus3.out_valid !== 1'b0 || bus3.count !== 2'd0 || bus3.out_data !== 32'hBBBB_0002)
            $display("FAIL bp empty: got valid=%b count=%0d data=%h want valid=0 count=0 data=bbbb0002", bus3.out_valid, bus3.count, bus3.out_data);
        else pass_cnt++;
    endtask

    task automatic test_simultaneous;
        logic [31:0] v;
        bus3.out_ready = 1'b1;
        bus3.in_valid = 1'b1;
        bus3.sel = 2'd1;
        for (int k = 0; k < 9; k++) begin
            v = 32'h1000_0000 + 32'(k * 32'h111);
            bus3.src_data = {32'h0, v, 32'h0};
            @(posedge clk); #1;
            total_cnt++; if (bus3.count !== 2'd1 || bus3.out_data !== v)
                $display("FAIL simul k=%0d: got count=%0d data=%h want count=1 data=%h", k, bus3.count, bus3.out_data, v);
            else pass_cnt++;
        end
        bus3.in_valid = 1'b0;
        @(posedge clk); #1;
        total_cnt++; if (bus3.count !== 2'd0) $display("FAIL simul drain: got count=%0d want 0", bus3.count); else pass_cnt++;
    endtask

    task automatic test_reset_mid;
        bus3.out_ready = 1'b0;
        bus3.in_valid = 1'b1;
        bus3.sel = 2'd1;
        bus3.src_data = {32'h1234_5678, 32'hCAFE_0001, 32'h0};
        @(posedge clk); #1;
        @(posedge clk); #1;
        bus3.in_valid = 1'b0;
        total_cnt++; if (bus3.count !== 2'd2) $display("FAIL mid pre-reset count: got %0d want 2", bus3.count); else pass_cnt++;
        #2 reset = 1'b1;
        #1;
        total_cnt++; if (bus3.out_valid !== 1'b0 || bus3.count !== 2'd0 || bus3.in_ready !== 1'b1 || bus3.out_data !== 32'h0)
            $display("FAIL mid reset: got valid=%b count=%0d in_ready=%b data=%h want 0/0/1/0", bus3.out_valid, bus3.count, bus3.in_ready, bus3.out_data);
        else pass_cnt++;
        reset = 1'b0;
        bus3.in_valid = 1'b1;
        bus3.sel = 2'd2;
        @(posedge clk); #1;
        bus3.in_valid = 1'b0;
        total_cnt++; if (bus3.count !== 2'd1 || bus3.out_data !== 32'h1234_5678 || bus3.in_ready !== 1'b1)
            $display("FAIL mid first accept: got count=%0d data=%h in_ready=%b want 1/12345678/1", bus3.count, bus3.out_data, bus3.in_ready);
        else pass_cnt++;
        bus3.out_ready = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_out_of_range;
        logic [2:0]  sels  [5];
        logic [31:0] exp_d [5];
        logic        exp_e [5];
        sels  = '{3'd3, 3'd4, 3'd7, 3'd1, 3'd1};
        exp_d = '{32'h4444_4444, 32'h0, 32'h0, 32'h2222_2222, 32'h2222_2222};
        exp_e = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
        bus4.src_data = {32'h4444_4444, 32'h3333_3333, 32'h2222_2222, 32'h1111_1111};
        bus4.out_ready = 1'b1;
        for (int k = 0; k < 5; k++) begin
            bus4.in_valid = (k < 4);
            bus4.sel = sels[k];
            @(posedge clk); #1;
            total_cnt++; if (bus4.out_data !== exp_d[k])
                $display("FAIL oor data k=%0d sel=%0d: got %h want %h", k, sels[k], bus4.out_data, exp_d[k]);
            else pass_cnt++;
`ifdef ALU_A_SEL_ERR_EN
            total_cnt++; if (bus4.sel_err !== exp_e[k])
                $display("FAIL oor sel_err k=%0d: got %b want %b", k, bus4.sel_err, exp_e[k]);
            else pass_cnt++;
`else
            if (exp_e[k] === 1'bx) $display("unexpected x");
`endif
        end
        bus4.in_valid = 1'b0;
`ifdef ALU_A_SEL_ERR_EN
        #2 reset = 1'b1;
        #1;
        total_cnt++; if (bus4.sel_err !== 1'b0) $display("FAIL oor sel_err after reset: got %b want 0", bus4.sel_err); else pass_cnt++;
        reset = 1'b0;
`endif
        @(posedge clk); #1;
    endtask

    initial begin
        test_reset();
        test_select_decode();
        test_backpressure();
        test_simultaneous();
        test_reset_mid();
        test_out_of_range();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
